// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared widths, reset vector, fetch state encodings and the
//                6502 opcode-field constants used to size instructions.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 16;
  localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC;

  // Every fetched byte takes a REQ cycle (strobe out) and a CAP cycle (data in)
  typedef enum logic [3:0] {
    FS_VEC_LO_REQ = 4'd0,
    FS_VEC_LO_CAP = 4'd1,
    FS_VEC_HI_REQ = 4'd2,
    FS_VEC_HI_CAP = 4'd3,
    FS_OP_REQ     = 4'd4,
    FS_OP_CAP     = 4'd5,
    FS_B1_REQ     = 4'd6,
    FS_B1_CAP     = 4'd7,
    FS_B2_REQ     = 4'd8,
    FS_B2_CAP     = 4'd9,
    FS_HOLD       = 4'd10
  } fetch_state_t;

  // Opcode layout is aaabbbcc; cc selects the group, bbb the addressing mode
  localparam logic [1:0] AM3_CC_00 = 2'b00;
  localparam logic [1:0] AM3_CC_01 = 2'b01;
  localparam logic [1:0] AM3_CC_10 = 2'b10;
  localparam logic [1:0] AM3_CC_11 = 2'b11;

  localparam logic [2:0] AM3_BBB_000 = 3'b000;
  localparam logic [2:0] AM3_BBB_001 = 3'b001;
  localparam logic [2:0] AM3_BBB_010 = 3'b010;
  localparam logic [2:0] AM3_BBB_011 = 3'b011;
  localparam logic [2:0] AM3_BBB_100 = 3'b100;
  localparam logic [2:0] AM3_BBB_101 = 3'b101;
  localparam logic [2:0] AM3_BBB_110 = 3'b110;
  localparam logic [2:0] AM3_BBB_111 = 3'b111;

  localparam logic [REG_WIDTH-1:0] OPC_JSR = 8'h20;

  // Instruction length in bytes (1..3) derived purely from the opcode
  function automatic logic [1:0] opcode_len(input logic [REG_WIDTH-1:0] opc);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    aaa = opc[7:5];
    bbb = opc[4:2];
    cc  = opc[1:0];
    opcode_len = 2'd2;
    case (cc)
      AM3_CC_01: begin
        if (bbb == AM3_BBB_011 || bbb == AM3_BBB_110 || bbb == AM3_BBB_111)
          opcode_len = 2'd3;
      end
      AM3_CC_10: begin
        if (bbb == AM3_BBB_010 || bbb == AM3_BBB_110)
          opcode_len = 2'd1;
        else if (bbb == AM3_BBB_011 || bbb == AM3_BBB_111)
          opcode_len = 2'd3;
      end
      AM3_CC_00: begin
        case (bbb)
          AM3_BBB_000: begin
            if (opc == OPC_JSR)          opcode_len = 2'd3;
            else if (aaa >= 3'b101)      opcode_len = 2'd2;
            else                         opcode_len = 2'd1;
          end
          AM3_BBB_010, AM3_BBB_110:      opcode_len = 2'd1;
          AM3_BBB_011, AM3_BBB_111:      opcode_len = 2'd3;
          AM3_BBB_001, AM3_BBB_100,
          AM3_BBB_101:                   opcode_len = 2'd2;
          default:                       opcode_len = 2'd2;
        endcase
      end
      default: opcode_len = 2'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Memory read port, redirect request and decoder bundle
//                handshake of the instruction fetch unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [REG_WIDTH-1:0]  mem_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  jmp_valid;
  logic [ADDR_WIDTH-1:0] jmp_addr;
  logic                  instr_valid;
  logic                  instr_ack;
  logic [REG_WIDTH-1:0]  instr_opcode;
  logic [REG_WIDTH-1:0]  instr_op1;
  logic [REG_WIDTH-1:0]  instr_op2;
  logic [1:0]            instr_len;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_illegal;

  // Fetch unit side
  modport master (
    input  mem_data, jmp_valid, jmp_addr, instr_ack,
    output mem_addr, mem_rd, instr_valid, instr_opcode, instr_op1,
           instr_op2, instr_len, instr_pc, instr_illegal
  );

  // Memory / decoder / redirect side
  modport slave (
    output mem_data, jmp_valid, jmp_addr, instr_ack,
    input  mem_addr, mem_rd, instr_valid, instr_opcode, instr_op1,
           instr_op2, instr_len, instr_pc, instr_illegal
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_instr_length.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_instr_length
//  Description : Combinational opcode sizer: byte count and unsupported-group
//                flag for a 6502 opcode.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit_instr_length
  import fetch_unit_pkg::*;
(
  input  logic [REG_WIDTH-1:0] opcode,
  output logic [1:0]           len,
  output logic                 illegal
);

  // cc=11 opcodes are not part of the supported set and are sized as 1 byte
  always_comb begin
    len     = opcode_len(opcode);
    illegal = (opcode[1:0] == AM3_CC_11);
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch front end. Loads PC from the reset vector,
//                reads opcode + operand bytes and hands one complete
//                instruction bundle to the decoder per handshake. Redirects
//                on jump requests.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] VECTOR_ADDR = RESET_VECTOR
)
(
  input  logic          clk,
  input  logic          reset_n,
  fetch_unit_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

  fetch_state_t          state;
  fetch_state_t          next_state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [REG_WIDTH-1:0]  vec_lo;
  logic                  mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [1:0]            dec_len;
  logic                  dec_illegal;

  // Sizes the byte currently on the read bus; only consumed in OP_CAP
  fetch_unit_instr_length u_len (
    .opcode  (bus.mem_data),
    .len     (dec_len),
    .illegal (dec_illegal)
  );

  // Next state and next PC; a redirect overrides everything
  always_comb begin
    next_state = state;
    next_pc    = pc;
    if (bus.jmp_valid) begin
      next_state = FS_OP_REQ;
      next_pc    = bus.jmp_addr;
    end else begin
      case (state)
        // A REQ state moves on only once its strobe is actually on the bus;
        // that is false solely for the first cycle out of reset.
        FS_VEC_LO_REQ: if (bus.mem_rd) next_state = FS_VEC_LO_CAP;
        FS_VEC_LO_CAP: next_state = FS_VEC_HI_REQ;
        FS_VEC_HI_REQ: if (bus.mem_rd) next_state = FS_VEC_HI_CAP;
        FS_VEC_HI_CAP: begin
          next_state = FS_OP_REQ;
          next_pc    = {bus.mem_data, vec_lo};
        end
        FS_OP_REQ:     if (bus.mem_rd) next_state = FS_OP_CAP;
        FS_OP_CAP: begin
          next_pc    = pc + PC_STEP;
          next_state = (dec_len == 2'd1) ? FS_HOLD : FS_B1_REQ;
        end
        FS_B1_REQ:     if (bus.mem_rd) next_state = FS_B1_CAP;
        FS_B1_CAP: begin
          next_pc    = pc + PC_STEP;
          next_state = (bus.instr_len == 2'd3) ? FS_B2_REQ : FS_HOLD;
        end
        FS_B2_REQ:     if (bus.mem_rd) next_state = FS_B2_CAP;
        FS_B2_CAP: begin
          next_pc    = pc + PC_STEP;
          next_state = FS_HOLD;
        end
        FS_HOLD:       if (bus.instr_ack) next_state = FS_OP_REQ;
        default:       next_state = FS_VEC_LO_REQ;
      endcase
    end
  end

  // Read strobe/address to present while in the upcoming state
  always_comb begin
    mem_rd_d   = 1'b0;
    mem_addr_d = bus.mem_addr;
    case (next_state)
      FS_VEC_LO_REQ: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = VECTOR_ADDR;
      end
      FS_VEC_HI_REQ: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = VECTOR_ADDR + PC_STEP;
      end
      FS_OP_REQ, FS_B1_REQ, FS_B2_REQ: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = next_pc;
      end
      default: ;
    endcase
  end

  // State, PC, registered bus outputs and the captured instruction bundle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= FS_VEC_LO_REQ;
      pc                <= '0;
      vec_lo            <= '0;
      bus.mem_rd        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.instr_valid   <= 1'b0;
      bus.instr_opcode  <= '0;
      bus.instr_op1     <= '0;
      bus.instr_op2     <= '0;
      bus.instr_len     <= '0;
      bus.instr_pc      <= '0;
      bus.instr_illegal <= 1'b0;
    end else begin
      state           <= next_state;
      pc              <= next_pc;
      bus.mem_rd      <= mem_rd_d;
      bus.mem_addr    <= mem_addr_d;
      bus.instr_valid <= (next_state == FS_HOLD);
      // Data belonging to a read issued before a redirect is never captured
      if (!bus.jmp_valid) begin
        case (state)
          FS_VEC_LO_CAP: vec_lo <= bus.mem_data;
          FS_OP_CAP: begin
            bus.instr_opcode  <= bus.mem_data;
            bus.instr_pc      <= pc;
            bus.instr_len     <= dec_len;
            bus.instr_illegal <= dec_illegal;
            bus.instr_op1     <= '0;
            bus.instr_op2     <= '0;
          end
          FS_B1_CAP: bus.instr_op1 <= bus.mem_data;
          FS_B2_CAP: bus.instr_op2 <= bus.mem_data;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a byte memory model
//                and an expected-bundle queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [1:0]  len;
    logic [15:0] pc;
    logic        illegal;
  } bundle_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Byte memory: data appears the cycle after the strobe
  logic [7:0] mem [0:65535];
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;
  bundle_t exp_q[$];
  logic [15:0] rd_addr;
  int rd_at;
  bit rd_ok;

  function automatic bundle_t observed();
    return {bus.instr_opcode, bus.instr_op1, bus.instr_op2, bus.instr_len,
            bus.instr_pc, bus.instr_illegal};
  endfunction

  // Next cycle with a read strobe (bounded)
  task automatic wait_rd(output logic [15:0] addr, output int at, output bit ok);
    ok = 1'b0; at = 0; addr = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.mem_rd === 1'b1) begin
        addr = bus.mem_addr; at = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  // Next cycle with instr_valid (bounded)
  task automatic wait_valid(output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1) begin
        at = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse(input logic jmp, input logic [15:0] addr, input logic ack);
    bus.jmp_valid = jmp; bus.jmp_addr = addr; bus.instr_ack = ack;
    @(posedge clk);
    #1;
    bus.jmp_valid = 1'b0; bus.instr_ack = 1'b0;
  endtask

  task automatic test_reset();
    bus.jmp_valid = 1'b0; bus.jmp_addr = '0; bus.instr_ack = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.mem_rd, bus.mem_addr, bus.instr_valid, observed()} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {bus.mem_rd, bus.mem_addr, bus.instr_valid, observed()});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_vector();
    logic [15:0] a0;
    int t0;
    bit ok;
    wait_rd(a0, t0, ok);
    vectors++;
    if (!ok || a0 !== 16'hFFFC) begin
      errors++; $display("FAIL vec_lo_addr: got %h want fffc", a0);
    end
    wait_rd(rd_addr, rd_at, rd_ok);
    vectors++;
    if (!rd_ok || rd_addr !== 16'hFFFD || rd_at - t0 != 2) begin
      errors++; $display("FAIL vec_hi_addr: got %h at +%0d want fffd at +2", rd_addr, rd_at - t0);
    end
    wait_rd(rd_addr, rd_at, rd_ok);
    vectors++;
    if (!rd_ok || rd_addr !== 16'h8000 || rd_at - t0 != 4) begin
      errors++; $display("FAIL first_op_req: got %h at +%0d want 8000 at +4", rd_addr, rd_at - t0);
    end
  endtask

  task automatic test_lengths();
    bundle_t e;
    int v_at;
    bit ok;
    exp_q.push_back({8'hA9, 8'h42, 8'h00, 2'd2, 16'h8000, 1'b0});
    exp_q.push_back({8'h8D, 8'h00, 8'h02, 2'd3, 16'h8002, 1'b0});
    exp_q.push_back({8'hEA, 8'h00, 8'h00, 2'd1, 16'h8005, 1'b0});
    for (int k = 0; k < 3; k++) begin
      wait_valid(v_at, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || observed() !== e) begin
        errors++; $display("FAIL bundle_%0d: got %h want %h", k, observed(), e);
      end
      vectors++;
      if (v_at - rd_at != 2 * int'(e.len)) begin
        errors++; $display("FAIL latency_%0d: got %0d want %0d", k, v_at - rd_at, 2 * int'(e.len));
      end
      pulse(1'b0, 16'h0000, 1'b1);
      wait_rd(rd_addr, rd_at, rd_ok);
      vectors++;
      if (!rd_ok || rd_addr !== 16'(e.pc + 16'(e.len))) begin
        errors++; $display("FAIL next_pc_%0d: got %h want %h", k, rd_addr, 16'(e.pc + 16'(e.len)));
      end
    end
  endtask

  task automatic test_hold_stall();
    bundle_t e;
    int v_at;
    bit ok;
    exp_q.push_back({8'hA2, 8'h05, 8'h00, 2'd2, 16'h8006, 1'b0});
    wait_valid(v_at, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || observed() !== e) begin
      errors++; $display("FAIL hold_bundle: got %h want %h", observed(), e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.instr_valid, bus.mem_rd, observed()} !== {1'b1, 1'b0, e}) begin
        errors++;
        $display("FAIL hold_stable_%0d: got %h want %h", i,
                 {bus.instr_valid, bus.mem_rd, observed()}, {1'b1, 1'b0, e});
      end
    end
    pulse(1'b0, 16'h0000, 1'b1);
    wait_rd(rd_addr, rd_at, rd_ok);
    vectors++;
    if (!rd_ok || rd_addr !== 16'h8008) begin
      errors++; $display("FAIL hold_next_pc: got %h want 8008", rd_addr);
    end
  endtask

  task automatic test_jump();
    bundle_t e;
    int v_at;
    bit ok;
    // Redirect while the first operand byte is being captured
    repeat (3) @(negedge clk);
    pulse(1'b1, 16'hC000, 1'b0);
    wait_rd(rd_addr, rd_at, rd_ok);
    vectors++;
    if (!rd_ok || {bus.instr_valid, rd_addr} !== {1'b0, 16'hC000}) begin
      errors++; $display("FAIL jump_b1cap: got valid=%b addr=%h want valid=0 addr=c000", bus.instr_valid, rd_addr);
    end
    exp_q.push_back({8'hA9, 8'h77, 8'h00, 2'd2, 16'hC000, 1'b0});
    wait_valid(v_at, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || observed() !== e) begin
      errors++; $display("FAIL jump_bundle: got %h want %h", observed(), e);
    end
    // Jump and ack in the same cycle
    pulse(1'b1, 16'hC000, 1'b1);
    wait_rd(rd_addr, rd_at, rd_ok);
    vectors++;
    if (!rd_ok || {bus.instr_valid, rd_addr} !== {1'b0, 16'hC000}) begin
      errors++; $display("FAIL jump_ack: got valid=%b addr=%h want valid=0 addr=c000", bus.instr_valid, rd_addr);
    end
    // Ack with nothing valid must not disturb the fetch in progress
    exp_q.push_back({8'hA9, 8'h77, 8'h00, 2'd2, 16'hC000, 1'b0});
    pulse(1'b0, 16'h0000, 1'b1);
    wait_valid(v_at, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || observed() !== e || v_at - rd_at != 4) begin
      errors++; $display("FAIL stray_ack: got %h after %0d want %h after 4", observed(), v_at - rd_at, e);
    end
    pulse(1'b0, 16'h0000, 1'b1);
    wait_rd(rd_addr, rd_at, rd_ok);
    vectors++;
    if (!rd_ok || rd_addr !== 16'hC002) begin
      errors++; $display("FAIL jump_next_pc: got %h want c002", rd_addr);
    end
  endtask

  task automatic test_wrap_illegal();
    bundle_t e;
    int v_at;
    bit ok;
    pulse(1'b1, 16'hFFFF, 1'b0);
    exp_q.push_back({8'hEA, 8'h00, 8'h00, 2'd1, 16'hFFFF, 1'b0});
    exp_q.push_back({8'h03, 8'h00, 8'h00, 2'd1, 16'h0000, 1'b1});
    for (int k = 0; k < 2; k++) begin
      wait_valid(v_at, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || observed() !== e) begin
        errors++; $display("FAIL wrap_bundle_%0d: got %h want %h", k, observed(), e);
      end
      pulse(1'b0, 16'h0000, 1'b1);
      wait_rd(rd_addr, rd_at, rd_ok);
      vectors++;
      if (!rd_ok || rd_addr !== 16'(e.pc + 16'(e.len))) begin
        errors++; $display("FAIL wrap_next_pc_%0d: got %h want %h", k, rd_addr, 16'(e.pc + 16'(e.len)));
      end
    end
    // Operand fetch crossing FFFF -> 0000
    pulse(1'b1, 16'hFFFE, 1'b0);
    exp_q.push_back({8'h20, 8'hEA, 8'h03, 2'd3, 16'hFFFE, 1'b0});
    wait_valid(v_at, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || observed() !== e) begin
      errors++; $display("FAIL wrap_operands: got %h want %h", observed(), e);
    end
    pulse(1'b0, 16'h0000, 1'b1);
    wait_rd(rd_addr, rd_at, rd_ok);
    vectors++;
    if (!rd_ok || rd_addr !== 16'h0001) begin
      errors++; $display("FAIL wrap_operands_next: got %h want 0001", rd_addr);
    end
  endtask

  task automatic test_reset_mid();
    repeat (4) @(negedge clk);
    vectors++;
    if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0003}) begin
      errors++; $display("FAIL b2_req: got rd=%b addr=%h want rd=1 addr=0003", bus.mem_rd, bus.mem_addr);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.mem_rd, bus.mem_addr, bus.instr_valid, observed()} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h want 0",
               {bus.mem_rd, bus.mem_addr, bus.instr_valid, observed()});
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_rd(rd_addr, rd_at, rd_ok);
    vectors++;
    if (!rd_ok || rd_addr !== 16'hFFFC) begin
      errors++; $display("FAIL reset_mid_vector: got %h want fffc", rd_addr);
    end
    wait_rd(rd_addr, rd_at, rd_ok);
    wait_rd(rd_addr, rd_at, rd_ok);
    vectors++;
    if (!rd_ok || {bus.instr_valid, rd_addr} !== {1'b0, 16'h8000}) begin
      errors++; $display("FAIL reset_mid_restart: got valid=%b addr=%h want valid=0 addr=8000", bus.instr_valid, rd_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
    mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h02;
    mem[16'h8005] = 8'hEA;
    mem[16'h8006] = 8'hA2; mem[16'h8007] = 8'h05;
    mem[16'h8008] = 8'hA9; mem[16'h8009] = 8'h11;
    mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h77;
    mem[16'hFFFE] = 8'h20; mem[16'hFFFF] = 8'hEA;
    mem[16'h0000] = 8'h03;
    mem[16'h0001] = 8'hAD; mem[16'h0002] = 8'h34; mem[16'h0003] = 8'h12;

    test_reset();
    test_vector();
    test_lengths();
    test_hold_stall();
    test_jump();
    test_wrap_illegal();
    test_reset_mid();

    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want completion before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
